// File: rtl/mig_u_seq_alu_if.sv
// ----------------------------------------------------------------------------
// mig_u_seq_alu_if
// Issue-side and writeback-side handshake bundle for mig_u_seq_alu.
//   in_valid/in_ready : operation offered / accepted (transfer when both high)
//   cmd, in1, in2     : command and operands, sampled at transfer
//   out_valid/out_ready : result held / taken (consume when both high)
//   out, co, zero, neg : registered result and flags
// Modports: slave = the ALU, master = the issuer/consumer driving it.
// ----------------------------------------------------------------------------
interface mig_u_seq_alu_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       cmd;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             co;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, cmd, in1, in2, out_ready,
    input  in_ready, out_valid, out, co, zero, neg
  );

  modport slave (
    input  in_valid, cmd, in1, in2, out_ready,
    output in_ready, out_valid, out, co, zero, neg
  );
endinterface

// File: rtl/mig_u_seq_alu.sv
// ----------------------------------------------------------------------------
// mig_u_seq_alu
// Handshaked, registered ALU. Commands 0-11 (add/logic) complete in one cycle;
// shifts (12 SHL, 13 SHR, 14 SAR) take one cycle per bit of shift amount and
// MUL (15) is an unsigned shift-add taking exactly WIDTH cycles.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous reset, active-high; aborts any operation in flight
//   bus  : mig_u_seq_alu_if.slave (issue handshake, operands, result, flags)
// ----------------------------------------------------------------------------
module mig_u_seq_alu #(
  parameter int WIDTH = 64
) (
  input  logic           clk,
  input  logic           rst,
  mig_u_seq_alu_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  // One extra bit so the counter can hold WIDTH for a multiply.
  localparam int CNT_W   = SHAMT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef enum logic [3:0] {
    CMD_TRANSFER = 4'd0,  CMD_INC  = 4'd1,  CMD_ADD   = 4'd2,  CMD_ADD1  = 4'd3,
    CMD_ADDNB    = 4'd4,  CMD_SUB  = 4'd5,  CMD_DEC   = 4'd6,  CMD_TRANS2 = 4'd7,
    CMD_AND      = 4'd8,  CMD_OR   = 4'd9,  CMD_XOR   = 4'd10, CMD_NOT   = 4'd11,
    CMD_SHL      = 4'd12, CMD_SHR  = 4'd13, CMD_SAR   = 4'd14, CMD_MUL   = 4'd15
  } cmd_e;

  // Multi-cycle op kind equals cmd[1:0] for commands 12-15.
  typedef enum logic [1:0] {OP_SHL, OP_SHR, OP_SAR, OP_MUL} mop_e;

  state_e             state_q, state_d;
  mop_e               mop_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   b_q;      // value being shifted, or remaining multiplier bits
  logic [2*WIDTH-1:0] a_q;      // multiplicand, moved up one place per step
  logic [2*WIDTH-1:0] acc_q;    // product accumulator
  logic [WIDTH-1:0]   out_q;
  logic               co_q, zero_q, neg_q;

  logic               in_ready, out_valid, accept;
  logic               is_mul, single_op, last_step;
  logic [SHAMT_W-1:0] shamt;

  logic [WIDTH-1:0]   sel_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_co;

  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   step_b, step_res;
  logic               step_co;

  assign shamt     = bus.in2[SHAMT_W-1:0];
  assign is_mul    = (bus.cmd == CMD_MUL);
  // A shift by zero needs no BUSY cycles, so it retires like a logic op.
  assign single_op = (bus.cmd[3:2] != 2'b11) || (!is_mul && shamt == '0);
  assign last_step = (cnt_q == CNT_W'(1));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = single_op ? S_DONE : S_BUSY;
      S_BUSY: if (last_step) state_d = S_DONE;
      S_DONE: begin
        if (accept)             state_d = single_op ? S_DONE : S_BUSY;
        else if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = !rst && (state_q != S_BUSY) && ((state_q != S_DONE) || bus.out_ready);
    out_valid = (state_q == S_DONE);
    accept    = bus.in_valid && in_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out       = out_q;
  assign bus.co        = co_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

  // --------------------------------------------------------------------------
  // Single-cycle datapath: A + selB + cmd[0] for 0-7, logic ops for 8-11,
  // and pass-through of in1 for a zero-length shift.
  // --------------------------------------------------------------------------
  always_comb begin
    sel_b   = '0;
    alu_res = '0;
    alu_co  = 1'b0;
    unique case (bus.cmd[2:1])
      2'b00: sel_b = '0;
      2'b01: sel_b = bus.in2;
      2'b10: sel_b = ~bus.in2;
      2'b11: sel_b = '1;
      default: sel_b = '0;
    endcase
    sum = {1'b0, bus.in1} + {1'b0, sel_b} + {{WIDTH{1'b0}}, bus.cmd[0]};
    if (!bus.cmd[3]) begin
      {alu_co, alu_res} = sum;
    end else if (bus.cmd[2]) begin
      alu_res = bus.in1;
    end else begin
      unique case (bus.cmd[1:0])
        2'b00: alu_res = bus.in1 & bus.in2;
        2'b01: alu_res = bus.in1 | bus.in2;
        2'b10: alu_res = bus.in1 ^ bus.in2;
        2'b11: alu_res = ~bus.in1;
        default: alu_res = '0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Multi-cycle step: one shift bit or one multiplier bit per BUSY cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    acc_nx   = acc_q + (b_q[0] ? a_q : '0);
    step_b   = b_q;
    step_res = '0;
    step_co  = 1'b0;
    unique case (mop_q)
      OP_SHL: begin
        step_b  = {b_q[WIDTH-2:0], 1'b0};
        step_co = b_q[WIDTH-1];
      end
      OP_SHR: begin
        step_b  = {1'b0, b_q[WIDTH-1:1]};
        step_co = b_q[0];
      end
      OP_SAR: begin
        step_b  = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
        step_co = b_q[0];
      end
      OP_MUL: begin
        step_b  = {1'b0, b_q[WIDTH-1:1]};
        step_co = |acc_nx[2*WIDTH-1:WIDTH];
      end
      default: step_b = b_q;
    endcase
    step_res = (mop_q == OP_MUL) ? acc_nx[WIDTH-1:0] : step_b;
  end

  // --------------------------------------------------------------------------
  // Datapath registers. Result registers only change when a result is
  // produced, so they hold steady while the consumer stalls.
  // --------------------------------------------------------------------------
  // NOTE: every datapath register is reset, including working registers that
  // are reloaded before use, so nothing downstream ever sees X.
  always_ff @(posedge clk) begin
    if (rst) begin
      mop_q  <= OP_SHL;
      cnt_q  <= '0;
      b_q    <= '0;
      a_q    <= '0;
      acc_q  <= '0;
      out_q  <= '0;
      co_q   <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (accept) begin
      mop_q <= mop_e'(bus.cmd[1:0]);
      cnt_q <= is_mul ? CNT_W'(WIDTH) : CNT_W'(shamt);
      b_q   <= is_mul ? bus.in2 : bus.in1;
      a_q   <= {{WIDTH{1'b0}}, bus.in1};
      acc_q <= '0;
      if (single_op) begin
        out_q  <= alu_res;
        co_q   <= alu_co;
        zero_q <= (alu_res == '0);
        neg_q  <= alu_res[WIDTH-1];
      end
    end else if (state_q == S_BUSY) begin
      b_q   <= step_b;
      a_q   <= a_q << 1;
      acc_q <= acc_nx;
      cnt_q <= cnt_q - CNT_W'(1);
      if (last_step) begin
        out_q  <= step_res;
        co_q   <= step_co;
        zero_q <= (step_res == '0);
        neg_q  <= step_res[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_mig_u_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_mig_u_seq_alu
// Bench for mig_u_seq_alu at WIDTH=8. A reference model computes each
// accepted operation's result, flags and latency with plain arithmetic; one
// compare process checks every valid output cycle against it. Directed
// operations pin the model with hand-computed literals.
// ----------------------------------------------------------------------------
module tb_mig_u_seq_alu;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_results = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mig_u_seq_alu_if #(.WIDTH(W)) bus ();

  mig_u_seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [W-1:0] r;
    logic         co;
    int           lat;
    int           acc_cyc;
    bit           seen;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: result, carry and latency straight from the command set.
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   sh;
    logic [2*W-1:0] p;
    sh    = int'(b[2:0]);
    e.r   = '0;
    e.co  = 1'b0;
    e.lat = 1;
    e.seen = 0;
    e.acc_cyc = 0;
    case (c)
      4'd0:  e.r = a;
      4'd1:  begin e.r = a + 8'd1;        e.co = (a == 8'hFF); end
      4'd2:  begin e.r = a + b;           e.co = (int'(a) + int'(b) > 255); end
      4'd3:  begin e.r = a + b + 8'd1;    e.co = (int'(a) + int'(b) + 1 > 255); end
      4'd4:  begin e.r = a - b - 8'd1;    e.co = (a > b); end
      4'd5:  begin e.r = a - b;           e.co = (a >= b); end
      4'd6:  begin e.r = a - 8'd1;        e.co = (a != 0); end
      4'd7:  begin e.r = a;               e.co = 1'b1; end
      4'd8:  e.r = a & b;
      4'd9:  e.r = a | b;
      4'd10: e.r = a ^ b;
      4'd11: e.r = ~a;
      4'd12: begin
        p = {8'h00, a} << sh;
        e.r = p[W-1:0]; e.co = p[W]; e.lat = 1 + sh;
      end
      4'd13: begin
        e.r = a >> sh; e.co = (sh == 0) ? 1'b0 : a[sh-1]; e.lat = 1 + sh;
      end
      4'd14: begin
        e.r = $signed(a) >>> sh; e.co = (sh == 0) ? 1'b0 : a[sh-1]; e.lat = 1 + sh;
      end
      default: begin
        p = a * b;
        e.r = p[W-1:0]; e.co = (p[2*W-1:W] != 0); e.lat = 1 + W;
      end
    endcase
    return e;
  endfunction

  // Compare process: inputs change just after posedge, so at negedge the
  // handshake seen here is exactly what the next posedge will act on.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", bus.out_valid, 0);
      end else if (bus.out_valid) begin
        e = exp_q[0];
        if (!e.seen) begin
          check("latency", cyc - e.acc_cyc, e.lat);
          exp_q[0].seen = 1;
        end
        check("out",  bus.out,  e.r);
        check("co",   bus.co,   e.co);
        check("zero", bus.zero, e.r == 0);
        check("neg",  bus.neg,  e.r[W-1]);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          n_results++;
        end
      end else if (exp_q[0].seen || (cyc - exp_q[0].acc_cyc >= exp_q[0].lat)) begin
        check("valid_at_due", bus.out_valid, 1);
        exp_q[0].seen = 1;
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.cmd, bus.in1, bus.in2);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  // Issue one op with out_ready=1 and check its result against literals.
  task automatic run_op(input string nm, input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] eo,
                        input logic eco, input logic ez, input logic en);
    int k;
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check({nm, "_in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.cmd = c; bus.in1 = a; bus.in2 = b;
    k = cyc;
    @(posedge clk); #1;
    // Operands changing after transfer must not matter.
    bus.in_valid = 1'b0; bus.cmd = 4'($urandom); bus.in1 = 8'($urandom); bus.in2 = 8'($urandom);
    n = 0;
    while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check({nm, "_lat"},  cyc - k, exp_lat);
    check({nm, "_out"},  bus.out, eo);
    check({nm, "_co"},   bus.co, eco);
    check({nm, "_zero"}, bus.zero, ez);
    check({nm, "_neg"},  bus.neg, en);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    bit rnd_done;

    bus.in_valid = 1'b0; bus.cmd = '0; bus.in1 = '0; bus.in2 = '0; bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready",  bus.in_ready, 0);
    check("rst_out",       bus.out, 0);
    check("rst_co",        bus.co, 0);
    check("rst_zero",      bus.zero, 0);
    check("rst_neg",       bus.neg, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Directed literal vectors
    run_op("sub",   4'd5,  8'h05, 8'h07, 1, 8'hFE, 0, 0, 1);
    run_op("add",   4'd2,  8'hFF, 8'h01, 1, 8'h00, 1, 1, 0);
    run_op("sar",   4'd14, 8'h90, 8'h03, 4, 8'hF2, 0, 0, 1);
    run_op("shl",   4'd12, 8'h81, 8'h01, 2, 8'h02, 1, 0, 0);
    run_op("mul1",  4'd15, 8'h10, 8'h11, 9, 8'h10, 1, 0, 0);
    run_op("mul2",  4'd15, 8'h0F, 8'h03, 9, 8'h2D, 0, 0, 0);
    run_op("shr0",  4'd13, 8'hA5, 8'h08, 1, 8'hA5, 0, 0, 1);
    run_op("dec",   4'd6,  8'h00, 8'h00, 1, 8'hFF, 0, 0, 1);
    run_op("inc",   4'd1,  8'hFF, 8'h00, 1, 8'h00, 1, 1, 0);
    run_op("not",   4'd11, 8'h0F, 8'h00, 1, 8'hF0, 0, 0, 1);
    run_op("tr2",   4'd7,  8'h3C, 8'h00, 1, 8'h3C, 1, 0, 0);
    run_op("shr7",  4'd13, 8'h80, 8'h07, 8, 8'h01, 0, 0, 0);

    // Back-to-back XORs: one accepted and one retired per clock
    @(posedge clk); #1;
    r0 = n_results;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.cmd = 4'd10; bus.in1 = 8'(i * 37); bus.in2 = 8'hC3;
      check("b2b_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("b2b_last_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    check("b2b_results", n_results - r0, 4);

    // Backpressure: held result stays stable, next op waits, then goes through
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.cmd = 4'd10; bus.in1 = 8'h5A; bus.in2 = 8'hFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.cmd = 4'd9; bus.in1 = 8'h30; bus.in2 = 8'h03;
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready",  bus.in_ready, 0);
      check("bp_out",       bus.out, 8'hA5);
      check("bp_flags",     {bus.co, bus.zero, bus.neg}, 3'b001);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_next_valid", bus.out_valid, 1);
    check("bp_next_out",   bus.out, 8'h33);
    @(posedge clk); #1;

    // Reset three cycles into a multiply aborts it
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus.in_valid = 1'b1; bus.cmd = 4'd15; bus.in1 = 8'hFF; bus.in2 = 8'hFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready",  bus.in_ready, 0);
    check("abort_out",       bus.out, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("abort_no_stale", bus.out_valid, 0);
      @(posedge clk); #1;
    end
    run_op("post_abort_add", 4'd2, 8'h12, 8'h34, 1, 8'h46, 0, 0, 0);

    // Random stream with random consumer stalls, checked by the model
    rnd_done = 0;
    fork
      begin
        int m;
        for (int i = 0; i < 150; i++) begin
          bus.in_valid = 1'b1;
          bus.cmd = 4'($urandom); bus.in1 = 8'($urandom); bus.in2 = 8'($urandom);
          m = 0;
          @(negedge clk);
          while (!bus.in_ready && m < 60) begin @(negedge clk); m++; end
          if (m >= 60) check("rnd_accept_timeout", 0, 1);
          @(posedge clk); #1;
          if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        bus.in_valid = 1'b0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
